// File: rtl/gpi_filter.sv
// Field-input conditioner: two-flop synchroniser, shared sample prescaler and
// per-channel debounce counters. Define GPI_FILTER_EDGE_EN to build rise/fall pulses.
module gpi_filter #(
  parameter int GPI_W   = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [GPI_W-1:0]   din,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   filt_len,
  output logic [GPI_W-1:0]   gpi,
  output logic [GPI_W-1:0]   rise,
  output logic [GPI_W-1:0]   fall
);

  logic [GPI_W-1:0]   sync1;
  logic [GPI_W-1:0]   sync2;
  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic [CNT_W-1:0]   cnt [GPI_W];
  logic [CNT_W:0]     filt_eff;
  logic [GPI_W-1:0]   accept;

  // Using >= rather than == makes a lowered presc fire on the next cycle
  // instead of letting pcnt run up to all-ones and wrap.
  assign tick     = (pcnt >= presc);
  assign filt_eff = (filt_len == '0) ? (CNT_W+1)'(1) : {1'b0, filt_len};

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    accept = '0;
    for (int i = 0; i < GPI_W; i++) begin
      accept[i] = (sync2[i] != gpi[i]) && tick &&
                  (({1'b0, cnt[i]} + (CNT_W+1)'(1)) >= filt_eff);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      sync1 <= '0;
      sync2 <= '0;
      pcnt  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      pcnt  <= tick ? '0 : pcnt + PRESC_W'(1);
    end
  end

  // NOTE: the counter array is reset explicitly because a reset mid-filter must discard partial counts.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      gpi <= '0;
      for (int i = 0; i < GPI_W; i++) cnt[i] <= '0;
    end else begin
      gpi <= (gpi & ~accept) | (sync2 & accept);
      for (int i = 0; i < GPI_W; i++) begin
        if (sync2[i] == gpi[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= accept[i] ? '0 : cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef GPI_FILTER_EDGE_EN
  // Pulses are registered alongside gpi so they line up with the new level.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_gpi_filter.sv
// Directed self-checking bench for gpi_filter; expected edge pulses follow
// whether GPI_FILTER_EDGE_EN is defined for the build.
module tb_gpi_filter;

`ifdef GPI_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        presetn;
  logic [15:0] din;
  logic [15:0] presc;
  logic [7:0]  filt_len;
  logic [15:0] gpi;
  logic [15:0] rise;
  logic [15:0] fall;

  int n_checks = 0;
  int n_fail   = 0;

  gpi_filter dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .din      (din),
    .presc    (presc),
    .filt_len (filt_len),
    .gpi      (gpi),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 pclk = ~pclk;

  function automatic logic [15:0] e16(input logic [15:0] v);
    return EDGE ? v : 16'h0000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    din     = 16'h0000;
    presetn = 1'b0;
    step(2);
    presetn = 1'b1;
  endtask

  task automatic test_reset();
    presc = 16'd0; filt_len = 8'd4;
    din = 16'hFFFF; presetn = 1'b0;
    step(3);
    n_checks++; if (gpi !== 16'h0000) begin n_fail++; $display("FAIL reset_gpi: got %h expected %h", gpi, 16'h0000); end
    n_checks++; if (rise !== 16'h0000) begin n_fail++; $display("FAIL reset_rise: got %h expected %h", rise, 16'h0000); end
    n_checks++; if (fall !== 16'h0000) begin n_fail++; $display("FAIL reset_fall: got %h expected %h", fall, 16'h0000); end
    presetn = 1'b1;
    step(5);
    n_checks++; if (gpi !== 16'h0000) begin n_fail++; $display("FAIL release_edge5_gpi: got %h expected %h", gpi, 16'h0000); end
    step(1);
    n_checks++; if (gpi !== 16'hFFFF) begin n_fail++; $display("FAIL release_edge6_gpi: got %h expected %h", gpi, 16'hFFFF); end
    n_checks++; if (rise !== e16(16'hFFFF)) begin n_fail++; $display("FAIL release_edge6_rise: got %h expected %h", rise, e16(16'hFFFF)); end
    step(1);
    n_checks++; if (rise !== 16'h0000) begin n_fail++; $display("FAIL release_edge7_rise: got %h expected %h", rise, 16'h0000); end
  endtask

  task automatic test_latency();
    presc = 16'd0; filt_len = 8'd3;
    do_reset();
    din[0] = 1'b1;
    step(4);
    n_checks++; if (gpi[0] !== 1'b0) begin n_fail++; $display("FAIL lat_rise_k3: got %b expected %b", gpi[0], 1'b0); end
    step(1);
    n_checks++; if (gpi[0] !== 1'b1) begin n_fail++; $display("FAIL lat_rise_k4_gpi: got %b expected %b", gpi[0], 1'b1); end
    n_checks++; if (rise !== e16(16'h0001)) begin n_fail++; $display("FAIL lat_rise_k4_pulse: got %h expected %h", rise, e16(16'h0001)); end
    step(1);
    n_checks++; if (rise !== 16'h0000) begin n_fail++; $display("FAIL lat_rise_k5_pulse: got %h expected %h", rise, 16'h0000); end
    din[0] = 1'b0;
    step(4);
    n_checks++; if (gpi[0] !== 1'b1 || fall !== 16'h0000) begin n_fail++; $display("FAIL lat_fall_early: got gpi0=%b fall=%h expected gpi0=1 fall=0000", gpi[0], fall); end
    step(1);
    n_checks++; if (gpi[0] !== 1'b0) begin n_fail++; $display("FAIL lat_fall_gpi: got %b expected %b", gpi[0], 1'b0); end
    n_checks++; if (fall !== e16(16'h0001)) begin n_fail++; $display("FAIL lat_fall_pulse: got %h expected %h", fall, e16(16'h0001)); end
    step(1);
    n_checks++; if (fall !== 16'h0000) begin n_fail++; $display("FAIL lat_fall_clear: got %h expected %h", fall, 16'h0000); end
  endtask

  task automatic test_glitch();
    bit seen = 1'b0;
    presc = 16'd0; filt_len = 8'd5;
    do_reset();
    din[3] = 1'b1;
    step(4);
    din[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (gpi[3] !== 1'b0 || rise[3] !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL glitch_rejected: got activity=%b expected %b", seen, 1'b0); end
    din[3] = 1'b1;
    step(6);
    n_checks++; if (gpi[3] !== 1'b0) begin n_fail++; $display("FAIL glitch_long_k5: got %b expected %b", gpi[3], 1'b0); end
    step(1);
    n_checks++; if (gpi[3] !== 1'b1 || rise !== e16(16'h0008)) begin n_fail++; $display("FAIL glitch_long_accept: got gpi3=%b rise=%h expected gpi3=1 rise=%h", gpi[3], rise, e16(16'h0008)); end
  endtask

  task automatic test_prescaler();
    int last = -1;
    int n_int = 0;
    int lat = -1;
    presc = 16'd9; filt_len = 8'd2;
    do_reset();
    for (int c = 0; c < 45 && n_int < 3; c++) begin
      step(1);
      if (dut.tick === 1'b1) begin
        if (last >= 0) begin
          n_int++;
          n_checks++; if (c - last !== 10) begin n_fail++; $display("FAIL presc_tick_interval: got %0d expected %0d", c - last, 10); end
        end
        last = c;
      end
    end
    n_checks++; if (n_int !== 3) begin n_fail++; $display("FAIL presc_tick_count: got %0d expected %0d", n_int, 3); end
    din[7] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (gpi[7] === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat < 12 || lat > 22) begin n_fail++; $display("FAIL presc_latency: got %0d expected 12..22", lat); end
  endtask

  task automatic test_boundaries();
    presc = 16'd0; filt_len = 8'd0;
    do_reset();
    din[1] = 1'b1;
    step(2);
    n_checks++; if (gpi[1] !== 1'b0) begin n_fail++; $display("FAIL flen0_early: got %b expected %b", gpi[1], 1'b0); end
    step(1);
    n_checks++; if (gpi[1] !== 1'b1) begin n_fail++; $display("FAIL flen0_accept: got %b expected %b", gpi[1], 1'b1); end

    filt_len = 8'd255;
    do_reset();
    din[15] = 1'b1;
    step(256);
    n_checks++; if (gpi[15] !== 1'b0) begin n_fail++; $display("FAIL flen255_early: got %b expected %b", gpi[15], 1'b0); end
    step(1);
    n_checks++; if (gpi[15] !== 1'b1 || rise !== e16(16'h8000)) begin n_fail++; $display("FAIL flen255_accept: got gpi15=%b rise=%h expected gpi15=1 rise=%h", gpi[15], rise, e16(16'h8000)); end

    filt_len = 8'd200;
    do_reset();
    din[2] = 1'b1;
    step(52);
    n_checks++; if (gpi[2] !== 1'b0) begin n_fail++; $display("FAIL flen_lower_hold: got %b expected %b", gpi[2], 1'b0); end
    filt_len = 8'd10;
    step(1);
    n_checks++; if (gpi[2] !== 1'b1) begin n_fail++; $display("FAIL flen_lower_accept: got %b expected %b", gpi[2], 1'b1); end
  endtask

  task automatic test_simultaneous();
    presc = 16'd0; filt_len = 8'd4;
    do_reset();
    din = 16'hA5A5;
    step(5);
    n_checks++; if (gpi !== 16'h0000) begin n_fail++; $display("FAIL simul_early: got %h expected %h", gpi, 16'h0000); end
    step(1);
    n_checks++; if (gpi !== 16'hA5A5) begin n_fail++; $display("FAIL simul_gpi: got %h expected %h", gpi, 16'hA5A5); end
    n_checks++; if (rise !== e16(16'hA5A5) || fall !== 16'h0000) begin n_fail++; $display("FAIL simul_edges: got rise=%h fall=%h expected rise=%h fall=0000", rise, fall, e16(16'hA5A5)); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    din = 16'h0000;
    step(3);
    presetn = 1'b0;
    step(1);
    n_checks++; if (gpi !== 16'h0000 || fall !== 16'h0000) begin n_fail++; $display("FAIL midreset_state: got gpi=%h fall=%h expected 0000 0000", gpi, fall); end
    presetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (gpi !== 16'h0000 || fall !== 16'h0000 || rise !== 16'h0000) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_quiet: got activity=%b expected %b", seen, 1'b0); end
  endtask

  initial begin
    presetn = 1'b0; din = 16'h0000; presc = 16'd0; filt_len = 8'd4;
    test_reset();
    test_latency();
    test_glitch();
    test_prescaler();
    test_boundaries();
    test_simultaneous();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
